uart_rx_os: RTL and testbench
=============================

// Module: uart_rx_os
// PURPOSE
// - Oversampling UART receiver: the receive-side peer of the team's UART transmitter.
// - Recovers 8N1 frames (optional parity) from an asynchronous RX line.
// - Delivers each byte through a one-entry holding register with a VALID/READY handshake.
// - Flags framing, parity and overrun errors.
// - Sits beside the transmitter inside the UART top level and feeds the host-side logic.
// PARAMETERS
// - CLK_FREQ    50_000_000  system clock frequency, Hz
// - BAUD        115200      line rate, bit/s
// - OVERSAMPLE  16          baud ticks per bit; must be even and >= 8
// - PARITY_EN   0           1 = one parity bit is expected between D7 and stop
// - PARITY_ODD  0           1 = odd parity, 0 = even parity (used only if PARITY_EN = 1)
// PORTS
// - CLK         in   1  system clock, rising edge
// - RST         in   1  asynchronous, active-low reset
// - RX          in   1  serial line, asynchronous to CLK; idles high
// - DATA_R      out  8  received byte, LSB first on the wire; stable while VALID_R = 1
// - VALID_R     out  1  DATA_R holds an unread byte
// - READY_R     in   1  consumer accepts DATA_R on a cycle where VALID_R && READY_R
// - FRAME_ERR   out  1  1-cycle pulse: stop bit sampled low
// - PARITY_ERR  out  1  1-cycle pulse: parity mismatch (byte still delivered)
// - OVERRUN     out  1  1-cycle pulse: new byte arrived while holding register full and not read
// BEHAVIOUR
// - Reset (RST = 0, asynchronous): all outputs 0; FSM in IDLE; synchronizer flops set to 1; tick counter cleared.
// - RX input passes through a 2-flop synchronizer before any use.
// - Tick generator: DIV = CLK_FREQ / (BAUD * OVERSAMPLE), integer division.
//   - 1-cycle tick strobe every DIV clocks.
//   - Counter restarts at 0 on each start-bit falling edge detected in IDLE, so phase aligns to the frame.
// - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, plus BREAK.
//   - IDLE: on synced RX 1->0, go to START and clear the sample counter.
//   - START: at tick OVERSAMPLE/2, sample RX. If high, it is a false start: return to IDLE with no flags. If low, go to DATA.
//   - DATA: sample every OVERSAMPLE ticks at bit centre. Shift LSB first into a shift register. After 8 bits, go to PARITY if PARITY_EN, else STOP.
//   - PARITY: sample one bit and compare it with the XOR of the data, inverted when PARITY_ODD.
//   - STOP, sample high: byte is good. Load the holding register and go to IDLE.
//   - STOP, sample low: pulse FRAME_ERR, discard the byte, go to BREAK.
//   - BREAK: stay until synced RX = 1, then go to IDLE. This prevents a false restart on a held-low line.
// - Latency: VALID_R rises on the cycle after the stop-bit centre sample. PARITY_ERR pulses on that same cycle.
// - Holding register and handshake:
//   - VALID_R clears on the cycle after VALID_R && READY_R.
//   - DATA_R never changes while VALID_R = 1, except by a load on the same cycle as a read.
//   - Byte completes, VALID_R = 0: load it; VALID_R = 1.
//   - Byte completes, VALID_R = 1 && READY_R = 1 (same cycle): load the new byte; VALID_R stays 1; no OVERRUN.
//   - Byte completes, VALID_R = 1 && READY_R = 0: drop the new byte; keep the old one; pulse OVERRUN.
// - Error pulses are mutually independent. A frame error suppresses PARITY_ERR for that frame.
// - RST asserted mid-frame aborts immediately. After release, the receiver waits in IDLE for a fresh falling edge; a partial frame is never delivered.
// - Counter widths: sample counter is clog2(OVERSAMPLE) bits, bit counter 3 bits, tick divider clog2(DIV) bits. All wrap explicitly at their terminal counts.
// STRUCTURE
// - Shared package/header (uart_pkg):
//   - state encodings (IDLE, START, DATA, PARITY, STOP, BREAK)
//   - the DIV computation macro/function
//   - default CLK_FREQ/BAUD constants, shared with the transmitter
// - One sub-module: uart_baud_tick.
//   - Parameterised divider with sync restart input; emits a tick strobe.
//   - Reused by the transmitter with OVERSAMPLE = 1.
// - FSM, shifter and holding register stay in this module.
// TESTING (CLK_FREQ = 50 MHz, BAUD = 115200, OVERSAMPLE = 16 -> DIV = 27, bit = 432 clk)
// - Frame 0xA5, READY_R = 1 -> DATA_R = 0xA5, VALID_R pulses 1 cycle; no error flags.
// - Frames 0x3C then 0xC3 back-to-back, READY_R = 0 -> DATA_R = 0x3C held, VALID_R = 1, OVERRUN pulses once at end of the 2nd frame.
// - Same as above, but READY_R = 1 exactly on the 2nd completion cycle -> DATA_R = 0xC3, no OVERRUN.
// - RX low for 100 clk then high -> false start; no VALID_R; next valid frame 0x55 received correctly.
// - Stop bit forced low on 0xFF -> FRAME_ERR 1 pulse, VALID_R stays 0. RX held low for 20 bit times, then 0x81 sent -> 0x81 received once.
// - PARITY_EN = 1, PARITY_ODD = 0: 0x07 sent with parity bit 0 -> DATA_R = 0x07 and PARITY_ERR pulse.
//   - RST pulled low at D4 of a frame -> outputs 0; the following frame 0x12 is received cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encodings, baud divider helper,
// and default line settings common to the transmitter and receiver.
package uart_pkg;

  localparam int CLK_FREQ_DEF = 50_000_000;
  localparam int BAUD_DEF     = 115200;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  function automatic int baud_div(
    input int clk_freq,
    input int baud,
    input int os
  );
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate tick generator: one-cycle strobe every DIV clocks,
// with a synchronous restart that realigns the phase.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == LAST) && !restart;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver with optional parity, one-entry
// holding register (VALID/READY) and framing/parity/overrun pulses.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = CLK_FREQ_DEF,
  parameter int BAUD       = BAUD_DEF,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX,
  output logic [7:0] DATA_R,
  output logic       VALID_R,
  input  logic       READY_R,
  output logic       FRAME_ERR,
  output logic       PARITY_ERR,
  output logic       OVERRUN
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
  localparam bit P_EN  = (PARITY_EN != 0);
  localparam bit P_ODD = (PARITY_ODD != 0);

  logic          rx_s1;
  logic          rx_s2;
  logic          rx_d;
  logic [2:0]    state;
  logic [SW-1:0] scnt;
  logic [2:0]    bcnt;
  logic [7:0]    shreg;
  logic          par_bad;
  logic          tick;
  logic          fall;
  logic          start_edge;
  logic          smp;
  logic          done;
  logic          ferr_now;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign fall       = rx_d && !rx_s2;
  assign start_edge = (state == ST_IDLE) && fall;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk     (CLK),
    .rst_n   (RST),
    .restart (start_edge),
    .tick    (tick)
  );

  // start bit is checked at half a bit, every later bit one full bit on
  always_comb begin
    smp = 1'b0;
    if (tick) begin
      if (state == ST_START) smp = (scnt == S_MID);
      else                   smp = (scnt == S_END);
    end
  end

  assign done     = (state == ST_STOP) && smp && rx_s2;
  assign ferr_now = (state == ST_STOP) && smp && !rx_s2;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= ST_IDLE;
      scnt    <= '0;
      bcnt    <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fall) begin
            state <= ST_START;
            scnt  <= '0;
          end
        end
        ST_START: begin
          if (tick) scnt <= smp ? '0 : scnt + SW'(1);
          if (smp) begin
            state   <= rx_s2 ? ST_IDLE : ST_DATA;
            bcnt    <= '0;
            par_bad <= 1'b0;
          end
        end
        ST_DATA: begin
          if (tick) scnt <= smp ? '0 : scnt + SW'(1);
          if (smp) begin
            shreg <= {rx_s2, shreg[7:1]};
            bcnt  <= (bcnt == 3'd7) ? 3'd0 : bcnt + 3'd1;
            if (bcnt == 3'd7) state <= P_EN ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (tick) scnt <= smp ? '0 : scnt + SW'(1);
          if (smp) begin
            par_bad <= rx_s2 ^ (^shreg) ^ P_ODD;
            state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tick) scnt <= smp ? '0 : scnt + SW'(1);
          if (smp) state <= rx_s2 ? ST_IDLE : ST_BREAK;
        end
        ST_BREAK: begin
          if (rx_s2) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      DATA_R     <= '0;
      VALID_R    <= 1'b0;
      FRAME_ERR  <= 1'b0;
      PARITY_ERR <= 1'b0;
      OVERRUN    <= 1'b0;
    end else begin
      FRAME_ERR  <= ferr_now;
      PARITY_ERR <= done && par_bad && P_EN;
      OVERRUN    <= done && VALID_R && !READY_R;
      if (done && (!VALID_R || READY_R)) begin
        DATA_R  <= shreg;
        VALID_R <= 1'b1;
      end else if (VALID_R && READY_R) begin
        VALID_R <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: directed frames plus randomized
// parity frames checked against a byte-queue reference model.
module tb_uart_rx_os;

  localparam int OS     = 16;
  localparam int DIV    = 27;
  localparam int BIT    = OS * DIV;
  localparam int DIVP   = 4;
  localparam int BITP   = OS * DIVP;
  localparam int CLKF_P = 115200 * OS * DIVP;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rdy = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       fe;
  logic       pe;
  logic       ov;

  logic       rxp = 1'b1;
  logic       rdyp = 1'b1;
  logic [7:0] data_p;
  logic       valid_p;
  logic       fe_p;
  logic       pe_p;
  logic       ov_p;

  int n_cmp = 0;
  int n_bad = 0;

  int v_cyc;
  int n_fe;
  int n_pe;
  int n_ov;
  logic [7:0] got[$];
  int n_pe_p;
  int n_ov_p;
  logic [7:0] got_p[$];

  always #10 clk = ~clk;

  uart_rx_os #(
    .CLK_FREQ   (50_000_000),
    .BAUD       (115200),
    .OVERSAMPLE (OS),
    .PARITY_EN  (0),
    .PARITY_ODD (0)
  ) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .RX         (rx),
    .DATA_R     (data),
    .VALID_R    (valid),
    .READY_R    (rdy),
    .FRAME_ERR  (fe),
    .PARITY_ERR (pe),
    .OVERRUN    (ov)
  );

  uart_rx_os #(
    .CLK_FREQ   (CLKF_P),
    .BAUD       (115200),
    .OVERSAMPLE (OS),
    .PARITY_EN  (1),
    .PARITY_ODD (0)
  ) dut_p (
    .CLK        (clk),
    .RST        (rst_n),
    .RX         (rxp),
    .DATA_R     (data_p),
    .VALID_R    (valid_p),
    .READY_R    (rdyp),
    .FRAME_ERR  (fe_p),
    .PARITY_ERR (pe_p),
    .OVERRUN    (ov_p)
  );

  always @(negedge clk) begin
    if (valid) v_cyc++;
    if (valid && rdy) got.push_back(data);
    if (fe) n_fe++;
    if (pe) n_pe++;
    if (ov) n_ov++;
    if (valid_p && rdyp) got_p.push_back(data_p);
    if (pe_p) n_pe_p++;
    if (ov_p || fe_p) n_ov_p++;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear();
    v_cyc = 0;
    n_fe = 0;
    n_pe = 0;
    n_ov = 0;
    got.delete();
    n_pe_p = 0;
    n_ov_p = 0;
    got_p.delete();
  endtask

  // frame bits in wire order; nbits > 0 truncates the frame
  task automatic send(input bit p, input logic [7:0] b, input bit par,
                      input bit stop, input int nbits);
    logic [10:0] fr;
    int n;
    fr = '1;
    fr[0] = 1'b0;
    fr[8:1] = b;
    if (p) begin
      fr[9] = par;
      fr[10] = stop;
      n = 11;
    end else begin
      fr[9] = stop;
      n = 10;
    end
    if (nbits > 0 && nbits < n) n = nbits;
    for (int i = 0; i < n; i++) begin
      if (p) rxp = fr[i];
      else   rx = fr[i];
      cyc(p ? BITP : BIT);
    end
  endtask

  function automatic logic [31:0] qat(input int i);
    return (got.size() > i) ? 32'(got[i]) : 32'hFFFF_FFFF;
  endfunction

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int bad;
    int exp_pe;

    clear();
    cyc(5);
    check("rst_valid", 32'(valid), 0);
    check("rst_data", 32'(data), 0);
    check("rst_flags", 32'({fe, pe, ov}), 0);
    rst_n = 1'b1;
    cyc(50);

    clear();
    rdy = 1'b1;
    send(0, 8'hA5, 0, 1, 0);
    cyc(BIT);
    check("a5_cnt", 32'(got.size()), 1);
    check("a5_data", qat(0), 32'hA5);
    check("a5_vcyc", 32'(v_cyc), 1);
    check("a5_flags", 32'(n_fe + n_pe + n_ov), 0);

    clear();
    rdy = 1'b0;
    send(0, 8'h3C, 0, 1, 0);
    send(0, 8'hC3, 0, 1, 0);
    cyc(BIT);
    check("ovr_data", 32'(data), 32'h3C);
    check("ovr_valid", 32'(valid), 1);
    check("ovr_pulse", 32'(n_ov), 1);
    rdy = 1'b1;
    cyc(1);
    rdy = 1'b0;
    cyc(5);
    check("ovr_read", qat(0), 32'h3C);
    check("ovr_rcnt", 32'(got.size()), 1);
    check("ovr_vclr", 32'(valid), 0);

    clear();
    send(0, 8'h3C, 0, 1, 0);
    fork
      send(0, 8'hC3, 0, 1, 0);
      begin
        cyc(2 + DIV * (OS / 2 + 9 * OS) - 1);
        rdy = 1'b1;
        cyc(1);
        rdy = 1'b0;
      end
    join
    cyc(BIT);
    check("swap_data", 32'(data), 32'hC3);
    check("swap_valid", 32'(valid), 1);
    check("swap_ovr", 32'(n_ov), 0);
    check("swap_read", qat(0), 32'h3C);
    rdy = 1'b1;
    cyc(3);
    check("swap_read2", qat(1), 32'hC3);

    clear();
    rx = 1'b0;
    cyc(100);
    rx = 1'b1;
    cyc(600);
    check("fs_valid", 32'(v_cyc), 0);
    check("fs_flags", 32'(n_fe + n_pe + n_ov), 0);
    send(0, 8'h55, 0, 1, 0);
    cyc(BIT);
    check("fs_cnt", 32'(got.size()), 1);
    check("fs_data", qat(0), 32'h55);

    clear();
    send(0, 8'hFF, 0, 0, 0);
    cyc(20 * BIT);
    check("fe_pulse", 32'(n_fe), 1);
    check("fe_valid", 32'(v_cyc), 0);
    rx = 1'b1;
    cyc(BIT);
    send(0, 8'h81, 0, 1, 0);
    cyc(BIT);
    check("brk_cnt", 32'(got.size()), 1);
    check("brk_data", qat(0), 32'h81);
    check("brk_fe", 32'(n_fe), 1);

    clear();
    send(1, 8'h07, 0, 1, 0);
    cyc(BITP);
    check("par_cnt", 32'(got_p.size()), 1);
    check("par_data", (got_p.size() > 0) ? 32'(got_p[0]) : 32'hFFFF_FFFF, 32'h07);
    check("par_err", 32'(n_pe_p), 1);

    clear();
    rdy = 1'b0;
    send(0, 8'h99, 0, 1, 0);
    cyc(BIT);
    check("pre_rst_valid", 32'(valid), 1);
    send(0, 8'h5A, 0, 1, 5);
    rx = 1'b1;
    cyc(BIT / 2);
    rst_n = 1'b0;
    cyc(2);
    check("mid_rst_data", 32'(data), 0);
    check("mid_rst_valid", 32'(valid), 0);
    check("mid_rst_flags", 32'({fe, pe, ov}), 0);
    cyc(5);
    rst_n = 1'b1;
    cyc(BIT);
    clear();
    rdy = 1'b1;
    send(0, 8'h12, 0, 1, 0);
    cyc(BIT);
    check("post_rst_cnt", 32'(got.size()), 1);
    check("post_rst_data", qat(0), 32'h12);
    check("post_rst_flags", 32'(n_fe + n_pe + n_ov), 0);

    clear();
    exp_q.delete();
    exp_pe = 0;
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      bad = int'($urandom_range(0, 1));
      exp_q.push_back(b);
      exp_pe += bad;
      send(1, b, (^b) ^ bad[0], 1, 0);
      cyc(int'($urandom_range(0, 100)));
    end
    cyc(BITP);
    check("rnd_cnt", 32'(got_p.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("rnd_byte%0d", i),
            (got_p.size() > i) ? 32'(got_p[i]) : 32'hFFFF_FFFF,
            32'(exp_q[i]));
    end
    check("rnd_perr", 32'(n_pe_p), 32'(exp_pe));
    check("rnd_other", 32'(n_ov_p), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
